id_ex_stage: RTL and testbench

Decode-to-execute boundary of the 5-stage MIPS pipeline. Registers the 10-bit control vector produced by the decode-stage control unit together with operands and register specifiers into the EX stage. Detects load-use hazards and inserts one-cycle bubbles, squashes the ID instruction on redirect, and freezes on downstream hold. Keeps saturating stall and bubble counters for performance debug.

---
 rtl/id_ex_stage.sv | 123 ++++++++++++
 tb/tb_id_ex_stage.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, redirect squash,
// downstream hold and saturating stall/bubble performance counters.
module id_ex_stage #(
    parameter int unsigned DW = 32,
    parameter int unsigned CW = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [9:0]    ctrl_i,
    input  logic [DW-1:0] pc4_i,
    input  logic [DW-1:0] rs_data_i,
    input  logic [DW-1:0] rt_data_i,
    input  logic [DW-1:0] imm_i,
    input  logic [4:0]    rs_i,
    input  logic [4:0]    rt_i,
    input  logic [4:0]    rd_i,
    input  logic [5:0]    funct_i,
    input  logic          flush_i,
    input  logic          hold_i,
    input  logic          clr_cnt_i,
    output logic          stall_o,
    output logic [9:0]    ex_ctrl_o,
    output logic [DW-1:0] ex_pc4_o,
    output logic [DW-1:0] ex_rs_data_o,
    output logic [DW-1:0] ex_rt_data_o,
    output logic [DW-1:0] ex_imm_o,
    output logic [4:0]    ex_rs_o,
    output logic [4:0]    ex_rt_o,
    output logic [4:0]    ex_rd_o,
    output logic [5:0]    ex_funct_o,
    output logic [CW-1:0] stall_cnt_o,
    output logic [CW-1:0] bubble_cnt_o
);

    localparam logic [CW-1:0] CntMax = {CW{1'b1}};

    logic [9:0]    ctrl_q, ctrl_d;
    logic [DW-1:0] pc4_q, rs_data_q, rt_data_q, imm_q;
    logic [4:0]    rs_q, rt_q, rd_q;
    logic [5:0]    funct_q;
    logic [CW-1:0] stall_cnt_q, stall_cnt_d;
    logic [CW-1:0] bubble_cnt_q, bubble_cnt_d;

    logic use_rs, use_rt, hazard, bubble;

    // Hazard detection against a load sitting in EX; stall and bubble decisions.
    always_comb begin
        use_rt  = ctrl_i[7] | ctrl_i[3] | ctrl_i[1];
        use_rs  = (ctrl_i != 10'd0) & ~ctrl_i[0];
        hazard  = ctrl_q[2] & (rt_q != 5'd0) &
                  ((use_rs & (rt_q == rs_i)) | (use_rt & (rt_q == rt_i)));
        stall_o = hold_i | (hazard & ~flush_i);
        // Hold has priority: a frozen EX register never takes a bubble.
        bubble  = ~hold_i & (flush_i | hazard);
        ctrl_d  = bubble ? 10'd0 : ctrl_i;
    end

    // Saturating counters; clear overrides increment.
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (clr_cnt_i) begin
            stall_cnt_d  = '0;
            bubble_cnt_d = '0;
        end else begin
            if (stall_o && stall_cnt_q != CntMax) begin
                stall_cnt_d = stall_cnt_q + 1'b1;
            end
            if (bubble && bubble_cnt_q != CntMax) begin
                bubble_cnt_d = bubble_cnt_q + 1'b1;
            end
        end
    end

    // EX pipeline register; frozen while downstream holds.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ctrl_q    <= '0;
            pc4_q     <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            rd_q      <= '0;
            funct_q   <= '0;
        end else if (!hold_i) begin
            ctrl_q    <= ctrl_d;
            pc4_q     <= pc4_i;
            rs_data_q <= rs_data_i;
            rt_data_q <= rt_data_i;
            imm_q     <= imm_i;
            rs_q      <= rs_i;
            rt_q      <= rt_i;
            rd_q      <= rd_i;
            funct_q   <= funct_i;
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign ex_ctrl_o    = ctrl_q;
    assign ex_pc4_o     = pc4_q;
    assign ex_rs_data_o = rs_data_q;
    assign ex_rt_data_o = rt_data_q;
    assign ex_imm_o     = imm_q;
    assign ex_rs_o      = rs_q;
    assign ex_rt_o      = rt_q;
    assign ex_rd_o      = rd_q;
    assign ex_funct_o   = funct_q;
    assign stall_cnt_o  = stall_cnt_q;
    assign bubble_cnt_o = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus random traffic
// compared against a behavioural pipeline model.
module tb_id_ex_stage;

    localparam int DW = 32;
    localparam int CW = 16;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [9:0]    ctrl_i;
    logic [DW-1:0] pc4_i, rs_data_i, rt_data_i, imm_i;
    logic [4:0]    rs_i, rt_i, rd_i;
    logic [5:0]    funct_i;
    logic          flush_i, hold_i, clr_cnt_i;
    logic          stall_o;
    logic [9:0]    ex_ctrl_o;
    logic [DW-1:0] ex_pc4_o, ex_rs_data_o, ex_rt_data_o, ex_imm_o;
    logic [4:0]    ex_rs_o, ex_rt_o, ex_rd_o;
    logic [5:0]    ex_funct_o;
    logic [CW-1:0] stall_cnt_o, bubble_cnt_o;

    int checks = 0;
    int errors = 0;

    // Behavioural model of the instruction currently in EX plus counters.
    logic [9:0]    m_ctrl;
    logic [DW-1:0] m_pc4, m_rsd, m_rtd, m_imm;
    logic [4:0]    m_rs, m_rt, m_rd;
    logic [5:0]    m_funct;
    int            m_stall_cnt, m_bubble_cnt;

    id_ex_stage #(.DW(DW), .CW(CW)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .ctrl_i       (ctrl_i),
        .pc4_i        (pc4_i),
        .rs_data_i    (rs_data_i),
        .rt_data_i    (rt_data_i),
        .imm_i        (imm_i),
        .rs_i         (rs_i),
        .rt_i         (rt_i),
        .rd_i         (rd_i),
        .funct_i      (funct_i),
        .flush_i      (flush_i),
        .hold_i       (hold_i),
        .clr_cnt_i    (clr_cnt_i),
        .stall_o      (stall_o),
        .ex_ctrl_o    (ex_ctrl_o),
        .ex_pc4_o     (ex_pc4_o),
        .ex_rs_data_o (ex_rs_data_o),
        .ex_rt_data_o (ex_rt_data_o),
        .ex_imm_o     (ex_imm_o),
        .ex_rs_o      (ex_rs_o),
        .ex_rt_o      (ex_rt_o),
        .ex_rd_o      (ex_rd_o),
        .ex_funct_o   (ex_funct_o),
        .stall_cnt_o  (stall_cnt_o),
        .bubble_cnt_o (bubble_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_ctrl = '0; m_pc4 = '0; m_rsd = '0; m_rtd = '0; m_imm = '0;
        m_rs = '0; m_rt = '0; m_rd = '0; m_funct = '0;
        m_stall_cnt = 0; m_bubble_cnt = 0;
    endfunction

    // Does the ID instruction read the register that the load in EX writes?
    function automatic bit model_hazard();
        int dest;
        int srcs[$];
        dest = (m_ctrl[2] == 1'b1) ? int'(m_rt) : 0;
        if (ctrl_i != 0 && ctrl_i[0] == 1'b0) srcs.push_back(int'(rs_i));
        if (ctrl_i[7] || ctrl_i[3] || ctrl_i[1]) srcs.push_back(int'(rt_i));
        if (dest == 0) return 1'b0;
        foreach (srcs[i]) if (srcs[i] == dest) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit model_stall();
        return hold_i || (model_hazard() && !flush_i);
    endfunction

    function automatic void model_edge();
        bit s, b;
        s = model_stall();
        b = !hold_i && (flush_i || model_hazard());
        if (clr_cnt_i) begin
            m_stall_cnt = 0;
            m_bubble_cnt = 0;
        end else begin
            if (s && m_stall_cnt < CMAX) m_stall_cnt++;
            if (b && m_bubble_cnt < CMAX) m_bubble_cnt++;
        end
        if (!hold_i) begin
            m_ctrl = b ? 10'd0 : ctrl_i;
            m_pc4 = pc4_i; m_rsd = rs_data_i; m_rtd = rt_data_i; m_imm = imm_i;
            m_rs = rs_i; m_rt = rt_i; m_rd = rd_i; m_funct = funct_i;
        end
    endfunction

    task automatic check_outputs();
        chk("ex_ctrl", ex_ctrl_o, m_ctrl);
        chk("ex_pc4", ex_pc4_o, m_pc4);
        chk("ex_rs_data", ex_rs_data_o, m_rsd);
        chk("ex_rt_data", ex_rt_data_o, m_rtd);
        chk("ex_imm", ex_imm_o, m_imm);
        chk("ex_rs", ex_rs_o, m_rs);
        chk("ex_rt", ex_rt_o, m_rt);
        chk("ex_rd", ex_rd_o, m_rd);
        chk("ex_funct", ex_funct_o, m_funct);
        chk("stall_cnt", stall_cnt_o, m_stall_cnt);
        chk("bubble_cnt", bubble_cnt_o, m_bubble_cnt);
    endtask

    // Drive ID-side inputs (called just after a falling edge).
    task automatic drive(input logic [9:0] c, input logic [4:0] rs, input logic [4:0] rt,
                         input bit fl, input bit hd, input bit clr);
        ctrl_i = c; rs_i = rs; rt_i = rt; flush_i = fl; hold_i = hd; clr_cnt_i = clr;
        rd_i = 5'($urandom); funct_i = 6'($urandom);
        pc4_i = $urandom; rs_data_i = $urandom; rt_data_i = $urandom; imm_i = $urandom;
    endtask

    // One clock: check stall_o, advance the model at the edge, check registers.
    task automatic cycle(input bit do_chk);
        #1;
        if (do_chk) chk("stall_o", stall_o, model_stall());
        @(posedge clk_i);
        model_edge();
        #1;
        if (do_chk) check_outputs();
        @(negedge clk_i);
    endtask

    logic [9:0] ops [7];

    initial begin
        ops = '{10'h000, 10'h390, 10'h074, 10'h050, 10'h048, 10'h102, 10'h001};
        rst_i = 1'b0;
        drive(10'h000, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        model_reset();
        @(negedge clk_i);
        @(negedge clk_i);
        #1;
        chk("reset_stall", stall_o, 1'b0);
        check_outputs();
        rst_i = 1'b1;

        // Load-use on rs: lw $8 then add reading $8.
        drive(10'h074, 5'd1, 5'd8, 1'b0, 1'b0, 1'b0);
        cycle(1);
        drive(10'h390, 5'd8, 5'd9, 1'b0, 1'b0, 1'b0);
        #1 chk("lu_stall", stall_o, 1'b1);
        cycle(1);
        chk("lu_bubble_ctrl", ex_ctrl_o, 10'h000);
        chk("lu_bubble_cnt", bubble_cnt_o, 16'd1);
        chk("lu_stall_cnt", stall_cnt_o, 16'd1);
        #1 chk("lu_stall_once", stall_o, 1'b0);
        cycle(1);
        chk("lu_issue", ex_ctrl_o, 10'h390);

        // No false hazard: addi uses rs only; then load to $0.
        drive(10'h074, 5'd1, 5'd8, 1'b0, 1'b0, 1'b0);
        cycle(1);
        drive(10'h050, 5'd3, 5'd8, 1'b0, 1'b0, 1'b0);
        #1 chk("nf_stall", stall_o, 1'b0);
        cycle(1);
        chk("nf_issue", ex_ctrl_o, 10'h050);
        drive(10'h074, 5'd1, 5'd0, 1'b0, 1'b0, 1'b0);
        cycle(1);
        drive(10'h390, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        #1 chk("zero_stall", stall_o, 1'b0);
        cycle(1);

        // Flush during hazard: squashed, not stalled.
        drive(10'h074, 5'd1, 5'd8, 1'b0, 1'b0, 1'b1);
        cycle(1);
        drive(10'h390, 5'd8, 5'd8, 1'b1, 1'b0, 1'b0);
        #1 chk("fl_stall", stall_o, 1'b0);
        cycle(1);
        chk("fl_ctrl", ex_ctrl_o, 10'h000);
        chk("fl_bubble_cnt", bubble_cnt_o, 16'd1);
        chk("fl_stall_cnt", stall_cnt_o, 16'd0);

        // Hold for three cycles with changing ctrl and a flush pulse.
        drive(10'h048, 5'd4, 5'd5, 1'b0, 1'b0, 1'b1);
        cycle(1);
        drive(10'h390, 5'd6, 5'd7, 1'b0, 1'b1, 1'b0);
        cycle(1);
        drive(10'h102, 5'd6, 5'd7, 1'b1, 1'b1, 1'b0);
        cycle(1);
        drive(10'h050, 5'd6, 5'd7, 1'b0, 1'b1, 1'b0);
        cycle(1);
        chk("hold_frozen", ex_ctrl_o, 10'h048);
        chk("hold_cnt", stall_cnt_o, 16'd3);
        chk("hold_no_bubble", bubble_cnt_o, 16'd0);
        drive(10'h390, 5'd6, 5'd7, 1'b0, 1'b0, 1'b0);
        cycle(1);
        chk("hold_release", ex_ctrl_o, 10'h390);

        // Saturation via a long hold, then clear while holding.
        drive(10'h390, 5'd1, 5'd2, 1'b0, 1'b1, 1'b1);
        cycle(1);
        drive(10'h390, 5'd1, 5'd2, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < CMAX - 1; i++) cycle(0);
        chk("sat_preload", stall_cnt_o, 16'hFFFE);
        for (int i = 0; i < 3; i++) cycle(1);
        chk("sat_top", stall_cnt_o, 16'hFFFF);
        drive(10'h074, 5'd1, 5'd2, 1'b0, 1'b1, 1'b1);
        cycle(1);
        chk("sat_clear", stall_cnt_o, 16'd0);

        // Random traffic with a narrow register range to provoke hazards.
        for (int i = 0; i < 400; i++) begin
            drive(ops[$urandom_range(6)], 5'($urandom_range(3)), 5'($urandom_range(3)),
                  ($urandom_range(7) == 0), ($urandom_range(7) == 0),
                  ($urandom_range(31) == 0));
            cycle(1);
        end

        // Reset mid-stall with 0x274 in EX.
        drive(10'h274, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0);
        cycle(1);
        chk("pre_reset_ctrl", ex_ctrl_o, 10'h274);
        hold_i = 1'b1;
        #2 rst_i = 1'b0;
        model_reset();
        #1;
        check_outputs();
        hold_i = 1'b0;
        #1 chk("reset_stall_rel", stall_o, 1'b0);
        @(negedge clk_i);
        rst_i = 1'b1;
        drive(10'h390, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0);
        cycle(1);
        chk("post_reset_issue", ex_ctrl_o, 10'h390);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
